// File: rtl/pipe_ctrl.sv
// Hazard/stall controller for the 5-stage RV32I pipeline: prioritises memory waits,
// EXE-resolved jumps and load-use hazards, with a memory-wait watchdog and perf counters.
module pipe_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_reg1_re_i,
    input  logic [4:0]       id_reg1_raddr_i,
    input  logic             id_reg2_re_i,
    input  logic [4:0]       id_reg2_raddr_i,
    input  logic             exe_is_load_i,
    input  logic             exe_reg_we_i,
    input  logic [4:0]       exe_reg_waddr_i,
    input  logic             exe_jump_i,
    input  logic [31:0]      exe_jump_addr_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic [4:0]       stall_o,
    output logic [2:0]       flush_o,
    output logic             pc_redirect_o,
    output logic [31:0]      pc_redirect_addr_o,
    output logic             err_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    localparam logic [7:0]       LP_WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_next;
    logic             w_memstall;
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_loaduse;
    logic [2:0]       w_cnt_inc;
    logic [CNT_W-1:0] r_cnt [3];

    assign w_memstall = mem_req_i & ~mem_ack_i;
    assign w_rs1_hit  = id_reg1_re_i & (id_reg1_raddr_i == exe_reg_waddr_i);
    assign w_rs2_hit  = id_reg2_re_i & (id_reg2_raddr_i == exe_reg_waddr_i);
    assign w_loaduse  = exe_is_load_i & exe_reg_we_i & (exe_reg_waddr_i != 5'd0)
                      & (w_rs1_hit | w_rs2_hit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_wait_cnt_next    = r_wait_cnt;
        stall_o            = 5'b00000;
        flush_o            = 3'b000;
        pc_redirect_o      = 1'b0;
        pc_redirect_addr_o = 32'd0;
        err_o              = (r_state == S_ERROR);

        case (r_state)
            S_RUN: begin
                if (w_memstall) begin
                    w_state_next    = S_MEM_WAIT;
                    w_wait_cnt_next = 8'd1;
                end
            end
            S_MEM_WAIT: begin
                if (w_memstall) begin
                    if (r_wait_cnt == LP_WAIT_LAST) begin
                        w_state_next = S_ERROR;
                    end else begin
                        w_wait_cnt_next = r_wait_cnt + 8'd1;
                    end
                end else begin
                    w_state_next    = S_RUN;
                    w_wait_cnt_next = 8'd0;
                end
            end
            S_ERROR: begin
                w_state_next = S_ERROR;
            end
            default: begin
                w_state_next    = S_RUN;
                w_wait_cnt_next = 8'd0;
            end
        endcase

        // Reset masks every pipeline control regardless of what the stages present.
        if (rst_i) begin
            stall_o = 5'b00000;
        end else if (r_state == S_ERROR) begin
            stall_o = 5'b11111;
        end else if (w_memstall) begin
            stall_o = 5'b01111;
            flush_o = 3'b100;
        end else if (exe_jump_i) begin
            flush_o            = 3'b011;
            pc_redirect_o      = 1'b1;
            pc_redirect_addr_o = exe_jump_addr_i;
        end else if (w_loaduse) begin
            stall_o = 5'b00111;
            flush_o = 3'b010;
        end
    end

    assign w_cnt_inc = {pc_redirect_o, stall_o[0], 1'b1};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf_cnt
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_cnt[gi] <= '0;
                end else if (w_cnt_inc[gi]) begin
                    r_cnt[gi] <= r_cnt[gi] + LP_CNT_ONE;
                end
            end
        end
    endgenerate

    assign cycle_cnt_o = r_cnt[0];
    assign stall_cnt_o = r_cnt[1];
    assign flush_cnt_o = r_cnt[2];

endmodule
